// File: rtl/prom_programmer_if.sv
// Host-side and PROM-pin bundle for the PROM programmer.
// slave is the programmer's view; master is the host/PROM-model view.
interface prom_programmer_if;
  logic       start;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [4:0] err_addr;
  logic [4:0] prom_a;
  logic       prom_ce_n;
  logic       prom_pgm;
  logic [7:0] prom_d;
  logic [7:0] prom_q;

  modport slave (
    input  start, wr_valid, wr_data, prom_q,
    output wr_ready, busy, done, error, err_code, err_addr,
    output prom_a, prom_ce_n, prom_pgm, prom_d
  );

  modport master (
    output start, wr_valid, wr_data, prom_q,
    input  wr_ready, busy, done, error, err_code, err_addr,
    input  prom_a, prom_ce_n, prom_pgm, prom_d
  );
endinterface

// File: rtl/prom_programmer.sv
// Program-and-verify sequencer for a 32 x 8 fusible bipolar PROM.
// One host byte per address; each word is read, pulsed and re-read until it matches.
module prom_programmer #(
  parameter int unsigned READ_CYCLES    = 3,
  parameter int unsigned PULSE_CYCLES   = 10,
  parameter int unsigned RECOVER_CYCLES = 4,
  parameter int unsigned MAX_TRIES      = 8
) (
  input logic                clk,
  input logic                reset,
  prom_programmer_if.slave   prog
);

  localparam int unsigned MaxRP  = (READ_CYCLES > PULSE_CYCLES) ? READ_CYCLES : PULSE_CYCLES;
  localparam int unsigned MaxCyc = (MaxRP > RECOVER_CYCLES) ? MaxRP : RECOVER_CYCLES;
  localparam int unsigned CntW   = ($clog2(MaxCyc) > 0) ? $clog2(MaxCyc) : 1;
  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);

  localparam logic [CntW-1:0]   ReadLast    = CntW'(READ_CYCLES - 1);
  localparam logic [CntW-1:0]   PulseLast   = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0]   RecoverLast = CntW'(RECOVER_CYCLES - 1);
  localparam logic [TriesW-1:0] TriesMax    = TriesW'(MAX_TRIES);

  typedef enum logic [3:0] {
    StIdle, StFetch, StRead, StCheck, StPulse, StRecover, StNext, StDone, StError
  } state_e;

  state_e            state_q;
  logic [4:0]        addr_q;
  logic [7:0]        target_q;
  logic [7:0]        rdbk_q;
  logic [TriesW-1:0] tries_q;
  logic [CntW-1:0]   cnt_q;
  logic              wr_ready_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [1:0]        err_code_q;
  logic [4:0]        err_addr_q;
  logic [4:0]        prom_a_q;
  logic              prom_ce_n_q;
  logic              prom_pgm_q;
  logic [7:0]        prom_d_q;

  // Fuses already blown where the target wants a 0 can never be undone.
  logic [7:0] extra_ones;
  assign extra_ones = rdbk_q & ~target_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      target_q    <= '0;
      rdbk_q      <= '0;
      tries_q     <= '0;
      cnt_q       <= '0;
      wr_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= '0;
      err_addr_q  <= '0;
      prom_a_q    <= '0;
      prom_ce_n_q <= 1'b1;
      prom_pgm_q  <= 1'b0;
      prom_d_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (prog.start) begin
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
            addr_q     <= '0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b1;
            state_q    <= StFetch;
          end
        end
        StFetch: begin
          if (prog.wr_valid && wr_ready_q) begin
            target_q    <= prog.wr_data;
            tries_q     <= '0;
            cnt_q       <= '0;
            wr_ready_q  <= 1'b0;
            prom_a_q    <= addr_q;
            prom_ce_n_q <= 1'b0;
            state_q     <= StRead;
          end
        end
        StRead: begin
          if (cnt_q == ReadLast) begin
            rdbk_q      <= prog.prom_q;
            prom_ce_n_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= StCheck;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCheck: begin
          if (extra_ones != 8'h00) begin
            err_code_q <= 2'b01;
            err_addr_q <= addr_q;
            error_q    <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StError;
          end else if (rdbk_q == target_q) begin
            state_q <= StNext;
          end else if (tries_q == TriesMax) begin
            err_code_q <= 2'b10;
            err_addr_q <= addr_q;
            error_q    <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StError;
          end else begin
            prom_d_q   <= target_q & ~rdbk_q;
            prom_pgm_q <= 1'b1;
            tries_q    <= tries_q + 1'b1;
            cnt_q      <= '0;
            state_q    <= StPulse;
          end
        end
        StPulse: begin
          if (cnt_q == PulseLast) begin
            prom_pgm_q <= 1'b0;
            prom_d_q   <= '0;
            cnt_q      <= '0;
            state_q    <= StRecover;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRecover: begin
          if (cnt_q == RecoverLast) begin
            prom_ce_n_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StRead;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StNext: begin
          if (addr_q == 5'd31) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            addr_q     <= addr_q + 5'd1;
            wr_ready_q <= 1'b1;
            state_q    <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign prog.wr_ready  = wr_ready_q;
  assign prog.busy      = busy_q;
  assign prog.done      = done_q;
  assign prog.error     = error_q;
  assign prog.err_code  = err_code_q;
  assign prog.err_addr  = err_addr_q;
  assign prog.prom_a    = prom_a_q;
  assign prog.prom_ce_n = prom_ce_n_q;
  assign prog.prom_pgm  = prom_pgm_q;
  assign prog.prom_d    = prom_d_q;

endmodule

// File: doc/prom_programmer.md
Name: prom_programmer

Overview:
- Sequencer that programs and verifies a 32-word x 8-bit fusible bipolar PROM (5600-class part) from a host byte stream; the write-side counterpart of the read-only PROM model.
- Sits between a host/loader interface and the PROM pins: it drives address, CE_N and program pulses, and reads the PROM outputs back to verify.
- Fuse semantics: a cell can only go 0->1; blank devices read all zeros.

Parameters:
- READ_CYCLES, 3: clocks CE_N is held low before prom_q is sampled; covers the PROM access delay; minimum 1.
- PULSE_CYCLES, 10: clocks prom_pgm is held high per programming pulse; minimum 1.
- RECOVER_CYCLES, 4: clocks with prom_pgm low and CE_N high after each pulse; minimum 1.
- MAX_TRIES, 8: maximum programming pulses per address before failing; minimum 1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a 32-byte programming run
- wr_valid  input  1  host byte available
- wr_data  input  8  target byte for the current address
- wr_ready  output  1  block accepts wr_data this cycle
- busy  output  1  run in progress
- done  output  1  run completed with all 32 words verified
- error  output  1  run aborted
- err_code  output  2  01 = unprogrammable (a fused 1 where the target has 0), 10 = tries exhausted
- err_addr  output  5  address at which the error occurred
- prom_a  output  5  PROM address
- prom_ce_n  output  1  PROM chip enable, active low
- prom_pgm  output  1  programming pulse enable
- prom_d  output  8  bit mask to fuse during the pulse
- prom_q  input  8  PROM data outputs (readback)

Behaviour:
- Reset (synchronous, active-high, clk rising edge) forces:
  - state = IDLE
  - prom_ce_n = 1, prom_pgm = 0, prom_d = 0, prom_a = 0
  - wr_ready = 0, busy = 0, done = 0, error = 0, err_code = 0, err_addr = 0
- Reset mid-run (including mid-pulse) takes effect on the next edge. prom_pgm drops in that same cycle.
- States: IDLE, FETCH, READ, CHECK, PULSE, RECOVER, NEXT, DONE, ERROR.
- IDLE: when start = 1, clear done, error and err_code, set addr = 0, go to FETCH. busy = 1 in every state except IDLE, DONE and ERROR.
- FETCH:
  - wr_ready = 1 only in this state.
  - On wr_valid & wr_ready, latch wr_data into the target register, clear tries to 0, go to READ.
  - Exactly one byte is accepted per address, in address order 0..31.
- READ: prom_ce_n = 0 and prom_a = addr for READ_CYCLES clocks. prom_q is sampled into the readback register on the last READ cycle. Go to CHECK.
- CHECK (one cycle), first matching rule applies:
  - (q & ~target) != 0: err_code = 01, err_addr = addr, go to ERROR.
  - q == target: go to NEXT.
  - tries == MAX_TRIES: err_code = 10, err_addr = addr, go to ERROR.
  - Otherwise: prom_d = target & ~q, tries = tries + 1, go to PULSE.
- PULSE:
  - prom_pgm = 1, prom_ce_n = 1, prom_a = addr, prom_d held, for exactly PULSE_CYCLES clocks.
  - prom_a and prom_d must not change while prom_pgm = 1.
- RECOVER: prom_pgm = 0, prom_d = 0, prom_ce_n = 1 for RECOVER_CYCLES clocks, then go to READ (re-verify).
- NEXT: if addr == 31 go to DONE, else addr = addr + 1 and go to FETCH. The address counter never wraps within a run.
- DONE: done = 1 (held) until the next start.
- ERROR: error = 1, err_code and err_addr held until the next start; all PROM pins are idle.
- start is ignored in every state except IDLE, DONE and ERROR. From DONE or ERROR, start behaves as from IDLE.
- prom_ce_n and prom_pgm are never both active (0 and 1 respectively) in the same cycle.
- All outputs are registered.
- Latency for an already-matching byte: 1 (FETCH accept) + READ_CYCLES + 1 (CHECK) + 1 (NEXT) clocks.

Test Plan:
- Blank PROM model (reads 0), stream 32 bytes 0x00..0x1F, defaults:
  - address 0 needs no pulse;
  - each other address gets exactly one 10-cycle prom_pgm pulse with prom_d = data;
  - done = 1, error = 0 at the end.
- Model reads 0x0F at address 5, host sends 0xFF: one pulse at address 5 with prom_d = 0xF0, then a re-read of 0xFF, then NEXT.
- Model reads 0x81 at address 3, host sends 0x80: error = 1, err_code = 01, err_addr = 3, and no prom_pgm pulse is ever issued at address 3.
- Model ignores pulses at address 7 (stuck at 0), host sends 0x01: exactly 8 pulses, then error = 1, err_code = 10, err_addr = 7.
- Reset during a PULSE:
  - at the next edge prom_pgm = 0, prom_ce_n = 1, busy = 0, state = IDLE;
  - a new start then begins again at address 0.
- Hold wr_valid low for 20 clocks in FETCH at address 10:
  - no READ activity occurs and wr_ready stays 1;
  - wr_valid asserted together with a stray start is accepted and the run continues.
